// File: rtl/stripe_ctrl_pkg.sv
// Shared definitions for the stripe dispatch controller: state encodings and default word width.
package stripe_ctrl_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_STALL  = 2'd2,
        ST_RSVD   = 2'd3
    } state_t;

endpackage

// File: rtl/stripe_ctrl_sync_fifo.sv
// Small synchronous FIFO with combinational head output; pointers wrap on a power-of-two depth.
module sync_fifo
    import stripe_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_2f,
    input  logic              reset_L,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_en;
    logic              rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk_2f) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

endmodule

// File: rtl/stripe_ctrl.sv
// Buffers the input word stream and dispatches words to lane 0 / lane 1 in strict alternation.
// state     | meaning
// ST_IDLE   | FIFO empty, nothing to dispatch
// ST_ACTIVE | words buffered, dispatching as target lane allows
// ST_STALL  | head word waiting on the target lane's ready
// ST_RSVD   | unused, recovers to ST_IDLE
module stripe_ctrl
    import stripe_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic              clk_2f,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic              ready_0,
    input  logic              ready_1,
    output logic [DATA_W-1:0] lane_0,
    output logic [DATA_W-1:0] lane_1,
    output logic              valid_0,
    output logic              valid_1,
    output logic              next_lane,
    output logic [1:0]        state,
    output logic              overflow
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]     count;
    logic [CW-1:0]     next_count;
    logic [DATA_W-1:0] head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              tgt_ready;
    state_t            st;

    assign ready_out  = (count < CW'(DEPTH));
    assign push       = valid_in && ready_out;
    assign tgt_ready  = next_lane ? ready_1 : ready_0;
    // Never hop to the other lane: only the lane owed the next word can drain the head.
    assign pop        = !empty && tgt_ready;
    assign next_count = count + CW'(push) - CW'(pop);
    assign state      = st;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_2f  (clk_2f),
        .reset_L (reset_L),
        .push    (push),
        .pop     (pop),
        .din     (data_in),
        .dout    (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            st        <= ST_IDLE;
            next_lane <= 1'b0;
            lane_0    <= '0;
            lane_1    <= '0;
            valid_0   <= 1'b0;
            valid_1   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            valid_0 <= pop && !next_lane;
            valid_1 <= pop && next_lane;
            if (pop) begin
                if (next_lane) lane_1 <= head;
                else           lane_0 <= head;
                next_lane <= ~next_lane;
            end
            if (valid_in && full) overflow <= 1'b1;

            case (st)
                ST_IDLE: begin
                    if (next_count != '0) st <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (next_count == '0)          st <= ST_IDLE;
                    else if (!empty && !tgt_ready) st <= ST_STALL;
                end
                ST_STALL: begin
                    if (next_count == '0) st <= ST_IDLE;
                    else if (tgt_ready)   st <= ST_ACTIVE;
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stripe_ctrl.sv
// Self-checking bench for stripe_ctrl: directed scenarios plus random traffic against a queue model.
module tb_stripe_ctrl;
    import stripe_ctrl_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk_2f = 1'b0;
    logic          reset_L = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          valid_in = 1'b0;
    logic          ready_out;
    logic          ready_0 = 1'b0;
    logic          ready_1 = 1'b0;
    logic [DW-1:0] lane_0, lane_1;
    logic          valid_0, valid_1, next_lane, overflow;
    logic [1:0]    state;

    stripe_ctrl #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk_2f    (clk_2f),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .ready_0   (ready_0),
        .ready_1   (ready_1),
        .lane_0    (lane_0),
        .lane_1    (lane_1),
        .valid_0   (valid_0),
        .valid_1   (valid_1),
        .next_lane (next_lane),
        .state     (state),
        .overflow  (overflow)
    );

    always #5 clk_2f = ~clk_2f;

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: each accepted word is tagged with the parity of its acceptance index.
    typedef struct {
        logic [31:0] d;
        bit          ln;
    } entry_t;

    entry_t      mq[$];
    int          acc_n;
    int          disp_n;
    logic [31:0] m_l0, m_l1;
    bit          m_v0, m_v1, m_ovf;
    logic [1:0]  m_state;

    task automatic model_reset();
        mq.delete();
        acc_n = 0; disp_n = 0;
        m_l0 = '0; m_l1 = '0;
        m_v0 = 0; m_v1 = 0; m_ovf = 0;
        m_state = 2'd0;
    endtask

    task automatic compare_all(input string where);
        check_val({where, ".lane_0"},    lane_0,    m_l0);
        check_val({where, ".lane_1"},    lane_1,    m_l1);
        check_val({where, ".valid_0"},   valid_0,   m_v0);
        check_val({where, ".valid_1"},   valid_1,   m_v1);
        check_val({where, ".next_lane"}, next_lane, disp_n % 2);
        check_val({where, ".overflow"},  overflow,  m_ovf);
        check_val({where, ".state"},     state,     m_state);
    endtask

    // Inputs are applied away from the edge; expectations follow from the word queue.
    task automatic cycle(input bit vin, input logic [31:0] din, input bit r0, input bit r1);
        bit     can, push, disp, stall;
        entry_t e;
        valid_in = vin; data_in = din; ready_0 = r0; ready_1 = r1;
        #1;
        can = (mq.size() < DEPTH);
        check_val("ready_out", ready_out, can);
        push  = vin && can;
        disp  = (mq.size() > 0) && (mq[0].ln ? r1 : r0);
        stall = (mq.size() > 0) && !disp;
        m_v0 = 0; m_v1 = 0;
        if (disp) begin
            e = mq.pop_front();
            if (e.ln) begin m_l1 = e.d; m_v1 = 1; end
            else      begin m_l0 = e.d; m_v0 = 1; end
            disp_n++;
        end
        if (push) begin
            mq.push_back('{d: din, ln: acc_n[0]});
            acc_n++;
        end
        if (vin && !can) m_ovf = 1;
        m_state = (mq.size() == 0) ? 2'd0 : (stall ? 2'd2 : 2'd1);
        @(posedge clk_2f);
        #1;
        compare_all("cyc");
    endtask

    task automatic do_reset();
        valid_in = 0; ready_0 = 0; ready_1 = 0;
        reset_L = 0;
        #2;
        model_reset();
        compare_all("rst");
        check_val("rst.ready_out", ready_out, 1);
        @(posedge clk_2f);
        #1;
        reset_L = 1;
    endtask

    initial begin
        model_reset();
        #1;
        do_reset();

        // Back-to-back stream with both lanes ready, then drain to idle.
        cycle(1, 32'hFFFF_FFFF, 1, 1);
        cycle(1, 32'hEEEE_EEEE, 1, 1);
        cycle(1, 32'hDDDD_DDDD, 1, 1);
        cycle(1, 32'hCCCC_CCCC, 1, 1);
        repeat (3) cycle(0, 0, 1, 1);
        check_val("t1.idle", state, 2'd0);

        // Lane 1 blocked: second word waits in STALL.
        cycle(1, 32'hAAAA_AAAA, 1, 0);
        cycle(1, 32'hBBBB_BBBB, 1, 0);
        repeat (2) cycle(0, 0, 1, 0);
        check_val("t2.stall", state, 2'd2);
        cycle(0, 0, 1, 1);
        check_val("t2.lane_1", lane_1, 32'hBBBB_BBBB);
        repeat (2) cycle(0, 0, 1, 1);

        // Overfill with both lanes blocked, then drain.
        for (int i = 0; i < 5; i++) cycle(1, 32'h1000_0000 + i, 0, 0);
        check_val("t3.overflow", overflow, 1);
        repeat (6) cycle(0, 0, 1, 1);

        // Odd stream then idle: next_lane must persist.
        for (int i = 0; i < 3; i++) cycle(1, 32'h2000_0000 + i, 1, 1);
        repeat (3) cycle(0, 0, 1, 1);
        cycle(1, 32'h2000_0003, 1, 1);
        cycle(0, 0, 1, 1);
        check_val("t4.lane_1", lane_1, 32'h2000_0003);

        // Reset while holding words.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 32'h3000_0000 + i, 0, 0);
        do_reset();
        repeat (3) cycle(0, 0, 1, 1);

        // Full FIFO with push and pop in the same cycle.
        for (int i = 0; i < 4; i++) cycle(1, 32'h4000_0000 + i, 0, 0);
        cycle(1, 32'h4000_0004, 1, 0);
        check_val("t6.overflow", overflow, 1);
        repeat (6) cycle(0, 0, 1, 1);

        // Random traffic.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            cycle(($urandom_range(0, 3) != 0), $urandom(),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
